// File: rtl/elevator_ctrl.sv
// elevator_ctrl: single-cab elevator controller.
//   Latches cab (call_in) and hall (call_up/call_down) requests. The cab keeps
//   travelling in its current direction while requests remain that way, and
//   runs a door cycle (open, hold, close) at each served floor.
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   call_in/up/down   - per-floor request buttons, bit i = floor i
//   sensor_up/down    - one-cycle pulse when the cab reaches the next floor
//   sensor_inside     - doorway obstructed
//   sensor_door       - door fully closed
//   engine            - 00 stop, 01 up, 10 down (registered)
//   door              - 1 open command, 0 close command (registered)
//   level_display     - current floor (registered)
//   inactivate_*      - one-cycle pulses marking the request bits just served
module elevator_ctrl #(
    parameter int FLOORS  = 4,
    parameter int DELAY   = 8,
    parameter int LEVEL_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  call_in,
    input  logic [FLOORS-1:0]  call_up,
    input  logic [FLOORS-1:0]  call_down,
    input  logic               sensor_up,
    input  logic               sensor_down,
    input  logic               sensor_inside,
    input  logic               sensor_door,
    output logic [1:0]         engine,
    output logic               door,
    output logic [LEVEL_W-1:0] level_display,
    output logic [FLOORS-1:0]  inactivate_in_levels,
    output logic [FLOORS-1:0]  inactivate_out_up_levels,
    output logic [FLOORS-1:0]  inactivate_out_down_levels
);

    localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [LEVEL_W-1:0] TOP    = LEVEL_W'(FLOORS - 1);
    localparam logic [CNT_W-1:0]   RELOAD = CNT_W'(DELAY - 1);

    typedef enum logic [2:0] {
        IDLE, DOOR_OPEN, DOOR_WAIT, DOOR_CLOSE, MOVE_UP, MOVE_DOWN
    } state_t;

    state_t              state, state_n;
    logic                dir, dir_n;
    logic [LEVEL_W-1:0]  level_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [FLOORS-1:0]   req_in, req_up, req_dn, pend, here;
    logic [FLOORS-1:0]   clr_in, clr_up, clr_dn, block;
    logic                up_any, dn_any, both;
    logic [1:0]          engine_n;
    logic                door_n;

    function automatic logic any_above(input logic [FLOORS-1:0] p,
                                       input logic [LEVEL_W-1:0] l);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++)
            if (i > 32'(l)) r = r | p[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p,
                                       input logic [LEVEL_W-1:0] l);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++)
            if (i < 32'(l)) r = r | p[i];
        return r;
    endfunction

    always_comb begin
        pend = req_in | req_up | req_dn;
        for (int unsigned i = 0; i < FLOORS; i++)
            here[i] = (32'(level_display) == i);
        up_any = any_above(pend, level_display);
        dn_any = any_below(pend, level_display);
    end

    // State, level, counter and all outputs are registered here; the request
    // registers apply clears after sets so a coincident clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            dir                        <= 1'b1;
            level_display              <= '0;
            cnt                        <= '0;
            req_in                     <= '0;
            req_up                     <= '0;
            req_dn                     <= '0;
            engine                     <= 2'b00;
            door                       <= 1'b0;
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
        end else begin
            state                      <= state_n;
            dir                        <= dir_n;
            level_display              <= level_n;
            cnt                        <= cnt_n;
            req_in                     <= (req_in | (call_in   & ~block)) & ~clr_in;
            req_up                     <= (req_up | (call_up   & ~block)) & ~clr_up;
            req_dn                     <= (req_dn | (call_down & ~block)) & ~clr_dn;
            engine                     <= engine_n;
            door                       <= door_n;
            inactivate_in_levels       <= clr_in & req_in;
            inactivate_out_up_levels   <= clr_up & req_up;
            inactivate_out_down_levels <= clr_dn & req_dn;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        level_n = level_display;
        cnt_n   = cnt;
        clr_in  = '0;
        clr_up  = '0;
        clr_dn  = '0;
        block   = '0;
        both    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend[level_display]) begin
                    state_n = DOOR_OPEN;
                end else if (up_any && (dir || !dn_any)) begin
                    state_n = MOVE_UP;
                    dir_n   = 1'b1;
                end else if (dn_any) begin
                    state_n = MOVE_DOWN;
                    dir_n   = 1'b0;
                end
            end
            MOVE_UP: begin
                // Stop decision uses the floor just reached (level_n).
                if (sensor_up && level_display != TOP) begin
                    level_n = level_display + LEVEL_W'(1);
                    if (req_in[level_n] || req_up[level_n] ||
                        (req_dn[level_n] && !any_above(pend, level_n)) ||
                        level_n == TOP)
                        state_n = DOOR_OPEN;
                end
            end
            MOVE_DOWN: begin
                if (sensor_down && level_display != '0) begin
                    level_n = level_display - LEVEL_W'(1);
                    if (req_in[level_n] || req_dn[level_n] ||
                        (req_up[level_n] && !any_below(pend, level_n)) ||
                        level_n == '0)
                        state_n = DOOR_OPEN;
                end
            end
            DOOR_OPEN: begin
                if (!sensor_door) begin
                    state_n = DOOR_WAIT;
                    cnt_n   = RELOAD;
                    // With nothing left ahead, the cab may reverse, so both
                    // hall directions at this floor count as served.
                    both    = dir ? !up_any : !dn_any;
                    clr_in  = here;
                    if (dir || both)  clr_up = here;
                    if (!dir || both) clr_dn = here;
                end
            end
            DOOR_WAIT: begin
                block = here;
                if (sensor_inside || call_in[level_display] ||
                    call_up[level_display] || call_down[level_display])
                    cnt_n = RELOAD;
                else if (cnt == '0)
                    state_n = DOOR_CLOSE;
                else
                    cnt_n = cnt - CNT_W'(1);
            end
            DOOR_CLOSE: begin
                if (sensor_inside)
                    state_n = DOOR_OPEN;
                else if (sensor_door)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        engine_n = 2'b00;
        if (sensor_door) begin
            if (state_n == MOVE_UP)   engine_n = 2'b01;
            if (state_n == MOVE_DOWN) engine_n = 2'b10;
        end
        door_n = (state_n == DOOR_OPEN) || (state_n == DOOR_WAIT);
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
module tb_elevator_ctrl;
    localparam int F      = 4;
    localparam int D      = 3;
    localparam int LW     = 2;
    localparam int TRAVEL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [F-1:0]  call_in, call_up, call_down;
    logic          sensor_up, sensor_down, sensor_inside, sensor_door;
    logic [1:0]    engine;
    logic          door;
    logic [LW-1:0] level_display;
    logic [F-1:0]  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels;

    elevator_ctrl #(.FLOORS(F), .DELAY(D), .LEVEL_W(LW)) dut (
        .clk(clk), .reset(reset),
        .call_in(call_in), .call_up(call_up), .call_down(call_down),
        .sensor_up(sensor_up), .sensor_down(sensor_down),
        .sensor_inside(sensor_inside), .sensor_door(sensor_door),
        .engine(engine), .door(door), .level_display(level_display),
        .inactivate_in_levels(inactivate_in_levels),
        .inactivate_out_up_levels(inactivate_out_up_levels),
        .inactivate_out_down_levels(inactivate_out_down_levels)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          floor;
        logic [F-1:0] in_m;
        logic [F-1:0] up_m;
        logic [F-1:0] dn_m;
    } stop_t;

    int     checks = 0;
    int     errors = 0;
    stop_t  exp_q[$];
    stop_t  plan_q[$];
    int     m_pos;
    bit     m_dir;
    bit     mon_en = 1'b0;
    bit     env_on = 1'b0;
    int     travel_cnt = 0;
    int     close_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Physical cab: travels one floor per TRAVEL cycles while the engine
    // runs; the door reports open right after the open command and closed
    // two cycles after the close command.
    task automatic env_step();
        if (engine != 2'b00) begin
            travel_cnt++;
            if (travel_cnt >= TRAVEL) begin
                travel_cnt  = 0;
                sensor_up   = (engine == 2'b01);
                sensor_down = (engine == 2'b10);
            end else begin
                sensor_up   = 1'b0;
                sensor_down = 1'b0;
            end
        end else begin
            travel_cnt  = 0;
            sensor_up   = 1'b0;
            sensor_down = 1'b0;
        end
        if (door) begin
            sensor_door = 1'b0;
            close_cnt   = 0;
        end else if (!sensor_door) begin
            close_cnt++;
            if (close_cnt >= 2) sensor_door = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (env_on) env_step();
    endtask

    task automatic pulse_up();
        sensor_up = 1'b1;
        tick();
        sensor_up = 1'b0;
    endtask

    task automatic finish_close();
        repeat (D) tick();
        sensor_door = 1'b1;
        tick();
    endtask

    task automatic press(input logic [F-1:0] ci, input logic [F-1:0] cu, input logic [F-1:0] cd);
        call_in = ci; call_up = cu; call_down = cd;
        tick();
        call_in = '0; call_up = '0; call_down = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic bit any_in(input logic [F-1:0] p, input int lo, input int hi);
        for (int i = 0; i < F; i++)
            if (i >= lo && i <= hi && p[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Floor-level service plan: from the model position and direction, list
    // every stop and the request bits it retires. A stop that would retire
    // nothing means the cab would reopen forever; such batches are rejected.
    task automatic plan_batch(input logic [F-1:0] ci, input logic [F-1:0] cu,
                              input logic [F-1:0] cd, output bit ok);
        logic [F-1:0] pin, pu, pd, all;
        int    pos, guard;
        bit    dir, fin;
        stop_t s;
        pin = ci; pu = cu; pd = cd;
        pos = m_pos; dir = m_dir; ok = 1'b1; guard = 0;
        plan_q.delete();
        while ((pin | pu | pd) != '0 && ok) begin
            all = pin | pu | pd;
            if (!all[pos]) begin
                if (any_in(all, pos + 1, F - 1) && (dir || !any_in(all, 0, pos - 1))) begin
                    dir = 1'b1;
                    pos = pos + 1;
                    while (!(pin[pos] || pu[pos] || (pd[pos] && !any_in(all, pos + 1, F - 1)) || pos == F - 1))
                        pos = pos + 1;
                end else begin
                    dir = 1'b0;
                    pos = pos - 1;
                    while (!(pin[pos] || pd[pos] || (pu[pos] && !any_in(all, 0, pos - 1)) || pos == 0))
                        pos = pos - 1;
                end
            end
            fin = dir ? !any_in(all, pos + 1, F - 1) : !any_in(all, 0, pos - 1);
            s.floor = pos; s.in_m = '0; s.up_m = '0; s.dn_m = '0;
            s.in_m[pos] = pin[pos];
            if (dir || fin)  s.up_m[pos] = pu[pos];
            if (!dir || fin) s.dn_m[pos] = pd[pos];
            if ((s.in_m | s.up_m | s.dn_m) == '0) ok = 1'b0;
            pin = pin & ~s.in_m; pu = pu & ~s.up_m; pd = pd & ~s.dn_m;
            plan_q.push_back(s);
            guard++;
            if (guard > 4 * F) ok = 1'b0;
        end
        if (ok) begin
            m_pos = pos;
            m_dir = dir;
        end
    endtask

    // Scoreboard monitor: every service pulse pops one expected stop.
    initial begin
        stop_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("door_engine_excl", int'(door && engine != 2'b00), 0);
                if ((inactivate_in_levels | inactivate_out_up_levels | inactivate_out_down_levels) != '0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got floor %0d in=%b up=%b dn=%b, required no service",
                                 level_display, inactivate_in_levels, inactivate_out_up_levels,
                                 inactivate_out_down_levels);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(level_display) != e.floor || inactivate_in_levels != e.in_m ||
                            inactivate_out_up_levels != e.up_m || inactivate_out_down_levels != e.dn_m) begin
                            errors++;
                            $display("FAIL sb_stop: got floor %0d in=%b up=%b dn=%b, required floor %0d in=%b up=%b dn=%b",
                                     level_display, inactivate_in_levels, inactivate_out_up_levels,
                                     inactivate_out_down_levels, e.floor, e.in_m, e.up_m, e.dn_m);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [F-1:0] ci, cu, cd, excl;
        bit ok, done;
        int idle_cnt;

        reset = 1'b1;
        call_in = '0; call_up = '0; call_down = '0;
        sensor_up = 1'b0; sensor_down = 1'b0; sensor_inside = 1'b0; sensor_door = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_engine", int'(engine), 0);
        chk("rst_door", int'(door), 0);
        chk("rst_level", int'(level_display), 0);
        chk("rst_inact", int'(inactivate_in_levels | inactivate_out_up_levels | inactivate_out_down_levels), 0);

        // Cab call to floor 2
        press(4'b0100, '0, '0);
        chk("s1_latch_idle", int'(engine), 0);
        tick();
        chk("s1_engine_up", int'(engine), 1);
        pulse_up();
        chk("s1_level1", int'(level_display), 1);
        chk("s1_pass1", int'(engine), 1);
        tick();
        pulse_up();
        chk("s1_arrive_level", int'(level_display), 2);
        chk("s1_arrive_engine", int'(engine), 0);
        chk("s1_arrive_door", int'(door), 1);
        sensor_door = 1'b0;
        tick();
        chk("s1_inact_in", int'(inactivate_in_levels), 4);
        for (int k = 1; k <= D; k++) begin
            tick();
            if (k == 1)     chk("s1_inact_once", int'(inactivate_in_levels), 0);
            if (k == D - 1) chk("s1_door_held", int'(door), 1);
            if (k == D)     chk("s1_door_closed", int'(door), 0);
        end
        sensor_door = 1'b1;
        tick();

        // Hall up at 1 and hall down at 3, starting from floor 0
        do_reset();
        press('0, 4'b0010, 4'b1000);
        tick();
        pulse_up();
        chk("s2_stop1_level", int'(level_display), 1);
        chk("s2_stop1_door", int'(door), 1);
        sensor_door = 1'b0;
        tick();
        chk("s2_stop1_up", int'(inactivate_out_up_levels), 2);
        chk("s2_stop1_dn", int'(inactivate_out_down_levels), 0);
        finish_close();
        tick();
        chk("s2_resume", int'(engine), 1);
        pulse_up();
        chk("s2_pass2", int'(level_display), 2);
        chk("s2_pass2_engine", int'(engine), 1);
        tick();
        pulse_up();
        chk("s2_stop3_level", int'(level_display), 3);
        chk("s2_stop3_door", int'(door), 1);
        sensor_door = 1'b0;
        tick();
        chk("s2_stop3_dn", int'(inactivate_out_down_levels), 8);
        chk("s2_stop3_up", int'(inactivate_out_up_levels), 0);
        pulse_up();
        chk("s5_top_level", int'(level_display), 3);
        chk("s5_top_engine", int'(engine), 0);
        finish_close();

        // Obstructed doorway in DOOR_WAIT and DOOR_CLOSE
        press(4'b1000, '0, '0);
        tick();
        chk("s3_open", int'(door), 1);
        sensor_door = 1'b0;
        tick();
        sensor_inside = 1'b1;
        repeat (5) tick();
        chk("s3_inside_held", int'(door), 1);
        sensor_inside = 1'b0;
        for (int k = 1; k <= D; k++) begin
            tick();
            if (k == D - 1) chk("s3_door_held", int'(door), 1);
            if (k == D)     chk("s3_door_closed", int'(door), 0);
        end
        sensor_inside = 1'b1;
        tick();
        chk("s3_reopen", int'(door), 1);
        sensor_inside = 1'b0;
        tick();
        finish_close();

        // Door not closed while moving up
        do_reset();
        press(4'b0100, '0, '0);
        tick();
        chk("s4_engine_up", int'(engine), 1);
        sensor_door = 1'b0;
        tick();
        chk("s4_door_open_stop", int'(engine), 0);
        tick();
        chk("s4_still_stopped", int'(engine), 0);
        sensor_door = 1'b1;
        tick();
        chk("s4_resume", int'(engine), 1);
        pulse_up();
        tick();
        pulse_up();
        sensor_door = 1'b0;
        tick();
        finish_close();

        // Reset while moving down
        press(4'b0001, '0, '0);
        tick();
        chk("s6_engine_down", int'(engine), 2);
        reset = 1'b1;
        #2;
        chk("s6_async_engine", int'(engine), 0);
        chk("s6_async_door", int'(door), 0);
        chk("s6_async_level", int'(level_display), 0);
        chk("s6_async_inact", int'(inactivate_in_levels | inactivate_out_up_levels | inactivate_out_down_levels), 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("s6_pending_cleared_door", int'(door), 0);
        chk("s6_pending_cleared_engine", int'(engine), 0);

        // Randomized batches against the floor-level service model
        m_pos = 0;
        m_dir = 1'b1;
        sensor_door = 1'b1;
        env_on = 1'b1;
        mon_en = 1'b1;
        for (int b = 0; b < 25; b++) begin
            ok = 1'b0;
            ci = '0; cu = '0; cd = '0;
            for (int a = 0; a < 20 && !ok; a++) begin
                excl = ~(F'(1) << m_pos);
                ci = F'($urandom) & excl;
                cu = F'($urandom) & F'($urandom) & excl;
                cd = F'($urandom) & F'($urandom) & excl;
                if ((ci | cu | cd) != '0) plan_batch(ci, cu, cd, ok);
            end
            if (!ok) begin
                ci = F'(1) << ((m_pos + 1) % F);
                cu = '0;
                cd = '0;
                plan_batch(ci, cu, cd, ok);
            end
            foreach (plan_q[i]) exp_q.push_back(plan_q[i]);
            press(ci, cu, cd);
            idle_cnt = 0;
            done = 1'b0;
            for (int c = 0; c < 3000 && !done; c++) begin
                tick();
                if (!door && engine == 2'b00 && sensor_door && exp_q.size() == 0)
                    idle_cnt++;
                else
                    idle_cnt = 0;
                if (idle_cnt >= 6) done = 1'b1;
            end
            chk("batch_done", int'(done), 1);
            if (!done) exp_q.delete();
            chk("batch_level", int'(level_display), m_pos);
        end
        mon_en = 1'b0;
        env_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
